// File: rtl/dmem_arbiter_if.sv
// Signal bundle around dmem_arbiter: CPU data bus, UDM debug bus and the shared memory port.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cpu_req_i;
    logic            cpu_we_i;
    logic [AW-1:0]   cpu_addr_bi;
    logic [DW-1:0]   cpu_wdata_bi;
    logic [DW/8-1:0] cpu_be_bi;
    logic            cpu_ack_o;
    logic            cpu_resp_o;
    logic [DW-1:0]   cpu_rdata_bo;

    logic            dbg_req_i;
    logic            dbg_we_i;
    logic [AW-1:0]   dbg_addr_bi;
    logic [DW-1:0]   dbg_wdata_bi;
    logic            dbg_ack_o;
    logic [DW-1:0]   dbg_rdata_bo;
    logic            dbg_boost_o;

    logic            mem_req_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_bo;
    logic [DW-1:0]   mem_wdata_bo;
    logic [DW/8-1:0] mem_be_bo;
    logic [DW-1:0]   mem_rdata_bi;

    // Arbiter side of the bundle.
    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_bi, cpu_wdata_bi, cpu_be_bi,
        input  dbg_req_i, dbg_we_i, dbg_addr_bi, dbg_wdata_bi,
        input  mem_rdata_bi,
        output cpu_ack_o, cpu_resp_o, cpu_rdata_bo,
        output dbg_ack_o, dbg_rdata_bo, dbg_boost_o,
        output mem_req_o, mem_we_o, mem_addr_bo, mem_wdata_bo, mem_be_bo
    );

    // Requester/memory side of the bundle.
    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_bi, cpu_wdata_bi, cpu_be_bi,
        output dbg_req_i, dbg_we_i, dbg_addr_bi, dbg_wdata_bi,
        output mem_rdata_bi,
        input  cpu_ack_o, cpu_resp_o, cpu_rdata_bo,
        input  dbg_ack_o, dbg_rdata_bo, dbg_boost_o,
        input  mem_req_o, mem_we_o, mem_addr_bo, mem_wdata_bo, mem_be_bo
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between CPU and UDM debug bus; CPU has priority until the
// debug requester has lost STARVE_MAX cycles in a row, then debug wins one transaction.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} dbg_state_t;

    dbg_state_t            state;
    logic [7:0]            starve_cnt;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_dbg;
    logic [DW-1:0]         dbg_rdata_q;
    logic                  dbg_boost;
    logic                  dbg_elig;
    logic                  gnt_dbg;
    logic                  gnt_cpu;
    logic                  tail_cpu;
    logic                  tail_dbg;

    // Grants are held off while reset is asserted so every combinational output is quiet.
    assign dbg_boost = (starve_cnt == 8'(STARVE_MAX));
    assign dbg_elig  = rst_i && bus.dbg_req_i && (state == IDLE);
    assign gnt_dbg   = dbg_elig && (dbg_boost || !bus.cpu_req_i);
    assign gnt_cpu   = rst_i && bus.cpu_req_i && !gnt_dbg;
    assign tail_cpu  = tag_vld[RD_LATENCY-1] && !tag_dbg[RD_LATENCY-1];
    assign tail_dbg  = tag_vld[RD_LATENCY-1] &&  tag_dbg[RD_LATENCY-1];

    always_comb begin
        bus.mem_we_o     = 1'b0;
        bus.mem_addr_bo  = '0;
        bus.mem_wdata_bo = '0;
        bus.mem_be_bo    = '0;
        if (gnt_dbg) begin
            bus.mem_we_o     = bus.dbg_we_i;
            bus.mem_addr_bo  = bus.dbg_addr_bi;
            bus.mem_wdata_bo = bus.dbg_wdata_bi;
            bus.mem_be_bo    = '1;
        end else if (gnt_cpu) begin
            bus.mem_we_o     = bus.cpu_we_i;
            bus.mem_addr_bo  = bus.cpu_addr_bi;
            bus.mem_wdata_bo = bus.cpu_wdata_bi;
            bus.mem_be_bo    = bus.cpu_be_bi;
        end
    end

    assign bus.mem_req_o    = gnt_dbg || gnt_cpu;
    assign bus.cpu_ack_o    = gnt_cpu;
    assign bus.cpu_resp_o   = tail_cpu;
    assign bus.cpu_rdata_bo = tail_cpu ? bus.mem_rdata_bi : '0;
    assign bus.dbg_ack_o    = (state == ACK) || (gnt_dbg && bus.dbg_we_i);
    assign bus.dbg_rdata_bo = dbg_rdata_q;
    assign bus.dbg_boost_o  = dbg_boost;

    // Read-owner tag pipe: stage RD_LATENCY-1 lines up with mem_rdata_bi.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tag_vld <= '0;
            tag_dbg <= '0;
        end else begin
            tag_vld[0] <= bus.mem_req_o && !bus.mem_we_o;
            tag_dbg[0] <= gnt_dbg;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_dbg[i] <= tag_dbg[i-1];
            end
        end
    end

    // Debug FSM and starvation counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            case (state)
                IDLE:    if (gnt_dbg && !bus.dbg_we_i) state <= WAIT;
                WAIT:    if (tail_dbg) begin
                             dbg_rdata_q <= bus.mem_rdata_bi;
                             state       <= ACK;
                         end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (!bus.dbg_req_i || gnt_dbg)
                starve_cnt <= '0;
            else if (dbg_elig && !dbg_boost)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural memory and arbitration model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LATENCY = 2;
  localparam int STARVE_MAX = 8;
  localparam int NWORDS = 16;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        rd;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(RD_LATENCY), .STARVE_MAX(STARVE_MAX))
    dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_busy = 0;
  int m_starve = 0;
  logic last_dbg_ack = 1'b0;
  logic [31:0] ref_mem [NWORDS];
  exp_t cpu_q[$];
  exp_t dbg_q[$];

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Memory with fixed read latency; contents restored while reset is held.
  logic [31:0] mem [NWORDS];
  logic [31:0] rd_pipe [RD_LATENCY];
  always @(posedge clk_i) begin
    for (int i = RD_LATENCY - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= $urandom;
    if (!rst_i) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= init_word(i);
    end else if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < DW/8; b++)
          if (bus.mem_be_bo[b]) mem[bus.mem_addr_bo[5:2]][8*b +: 8] <= bus.mem_wdata_bo[8*b +: 8];
      end else begin
        rd_pipe[0] <= mem[bus.mem_addr_bo[5:2]];
      end
    end
  end
  assign bus.mem_rdata_bi = rd_pipe[RD_LATENCY-1];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%08h required=%08h", name, cyc, act, exp);
    end
  endtask

  task automatic ref_write(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_starve = 0;
    last_dbg_ack = 1'b0;
    cpu_q.delete();
    dbg_q.delete();
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic drive_idle();
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_bi = '0;
    bus.cpu_wdata_bi = '0; bus.cpu_be_bi = '0;
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_bi = '0; bus.dbg_wdata_bi = '0;
  endtask

  // Reference: CPU first, debug first once it has lost STARVE_MAX cycles; a debug read
  // blocks further debug issue until its ack, RD_LATENCY+1 cycles after grant.
  task automatic model_eval();
    logic elig, boost, gd, gc;
    logic [3:0] idx;
    exp_t e;
    elig  = bus.dbg_req_i && (m_busy == 0);
    boost = (m_starve == STARVE_MAX);
    gd    = elig && (boost || !bus.cpu_req_i);
    gc    = bus.cpu_req_i && !gd;
    check1("dbg_boost", bus.dbg_boost_o, boost);
    check1("cpu_ack", bus.cpu_ack_o, gc);
    check1("mem_req", bus.mem_req_o, gd || gc);
    if (gd) begin
      idx = bus.dbg_addr_bi[5:2];
      check1("mem_we_dbg", bus.mem_we_o, bus.dbg_we_i);
      check32("mem_addr_dbg", bus.mem_addr_bo, bus.dbg_addr_bi);
      check32("mem_be_dbg", 32'(bus.mem_be_bo), 32'h0000_000F);
      if (bus.dbg_we_i) begin
        check32("mem_wdata_dbg", bus.mem_wdata_bo, bus.dbg_wdata_bi);
        ref_write(idx, bus.dbg_wdata_bi, 4'hF);
        e.cyc = cyc; e.rd = 1'b0; e.data = '0;
      end else begin
        e.cyc = cyc + RD_LATENCY + 1; e.rd = 1'b1; e.data = ref_mem[idx];
      end
      dbg_q.push_back(e);
    end else if (gc) begin
      idx = bus.cpu_addr_bi[5:2];
      check1("mem_we_cpu", bus.mem_we_o, bus.cpu_we_i);
      check32("mem_addr_cpu", bus.mem_addr_bo, bus.cpu_addr_bi);
      check32("mem_be_cpu", 32'(bus.mem_be_bo), 32'(bus.cpu_be_bi));
      if (bus.cpu_we_i) begin
        check32("mem_wdata_cpu", bus.mem_wdata_bo, bus.cpu_wdata_bi);
        ref_write(idx, bus.cpu_wdata_bi, bus.cpu_be_bi);
      end else begin
        e.cyc = cyc + RD_LATENCY; e.rd = 1'b1; e.data = ref_mem[idx];
        cpu_q.push_back(e);
      end
    end
    last_dbg_ack = bus.dbg_ack_o;
    if (!bus.dbg_req_i || gd) m_starve = 0;
    else if (elig && m_starve < STARVE_MAX) m_starve++;
    if (m_busy > 0) m_busy--;
    if (gd && !bus.dbg_we_i) m_busy = RD_LATENCY + 1;
  endtask

  task automatic tick();
    #2;
    model_eval();
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic new_dbg(input logic we, input logic [31:0] addr, input logic [31:0] d);
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = we; bus.dbg_addr_bi = addr; bus.dbg_wdata_bi = d;
  endtask

  task automatic dbg_until_ack(input string name);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      seen = last_dbg_ack;
    end
    bus.dbg_req_i = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s actual=no dbg_ack_o required=dbg_ack_o within 12 cycles", name);
    end
  endtask

  task automatic run_random(input int n, input int cpu_pct, input int dbg_pct);
    for (int k = 0; k < n; k++) begin
      bus.cpu_req_i    = ($urandom_range(99) < cpu_pct);
      bus.cpu_we_i     = $urandom_range(1);
      bus.cpu_addr_bi  = 32'($urandom_range(NWORDS - 1)) << 2;
      bus.cpu_wdata_bi = $urandom;
      bus.cpu_be_bi    = 4'($urandom);
      if (!bus.dbg_req_i || last_dbg_ack) begin
        if ($urandom_range(99) < dbg_pct)
          new_dbg(1'($urandom_range(1)), 32'($urandom_range(NWORDS - 1)) << 2, $urandom);
        else
          bus.dbg_req_i = 1'b0;
      end else if ($urandom_range(99) < 3) begin
        bus.dbg_req_i = 1'b0;
      end
      tick();
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check1({tag, "_cpu_ack"}, bus.cpu_ack_o, 1'b0);
    check1({tag, "_cpu_resp"}, bus.cpu_resp_o, 1'b0);
    check1({tag, "_dbg_ack"}, bus.dbg_ack_o, 1'b0);
    check1({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
    check1({tag, "_dbg_boost"}, bus.dbg_boost_o, 1'b0);
    check32({tag, "_dbg_rdata"}, bus.dbg_rdata_bo, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (rst_i) begin
        if (cpu_q.size() != 0 && cpu_q[0].cyc == cyc) begin
          e = cpu_q.pop_front();
          check1("cpu_resp", bus.cpu_resp_o, 1'b1);
          check32("cpu_rdata", bus.cpu_rdata_bo, e.data);
        end else begin
          check1("cpu_resp_unexpected", bus.cpu_resp_o, 1'b0);
        end
        if (dbg_q.size() != 0 && dbg_q[0].cyc == cyc) begin
          e = dbg_q.pop_front();
          check1("dbg_ack", bus.dbg_ack_o, 1'b1);
          if (e.rd) check32("dbg_rdata", bus.dbg_rdata_bo, e.data);
        end else begin
          check1("dbg_ack_unexpected", bus.dbg_ack_o, 1'b0);
        end
      end
    end
  end

  initial begin : driver
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk_i);
    #2;
    check_quiet_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc++;

    // CPU byte-masked write while debug is idle.
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_bi = 32'h10;
    bus.cpu_wdata_bi = 32'hDEAD_BEEF; bus.cpu_be_bi = 4'b0011;
    tick();
    drive_idle();

    // Debug read with CPU idle, then read-back of the CPU write.
    new_dbg(1'b0, 32'h20, 32'h0);
    dbg_until_ack("dbg_read_0x20");
    new_dbg(1'b0, 32'h10, 32'h0);
    dbg_until_ack("dbg_read_0x10");

    // CPU read followed by debug read on the next cycle: both in flight together.
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_bi = 32'h4;
    tick();
    bus.cpu_req_i = 1'b0;
    new_dbg(1'b0, 32'h8, 32'h0);
    dbg_until_ack("dbg_read_0x8");

    // Same-cycle reads: CPU wins until it lets go; then continuous CPU traffic starves a debug write.
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_bi = 32'h0C;
    new_dbg(1'b0, 32'h14, 32'h0);
    repeat (3) tick();
    bus.cpu_req_i = 1'b0;
    dbg_until_ack("dbg_read_after_cpu");
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_bi = 32'h18;
    new_dbg(1'b1, 32'h1C, 32'hCAFE_F00D);
    repeat (STARVE_MAX + 3) tick();
    bus.dbg_req_i = 1'b0;
    repeat (2) tick();

    run_random(400, 50, 40);
    run_random(150, 100, 60);
    run_random(300, 20, 70);

    // Reset while a debug read waits for data: pending responses must never appear.
    drive_idle();
    repeat (RD_LATENCY + 3) tick();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_bi = 32'h24;
    tick();
    bus.cpu_req_i = 1'b0;
    new_dbg(1'b0, 32'h28, 32'h0);
    tick();
    bus.cpu_req_i = 1'b1;
    #4;
    rst_i = 1'b0;
    #1;
    check_quiet_outputs("async_reset");
    model_reset();
    repeat (2) @(negedge clk_i);
    drive_idle();
    rst_i = 1'b1;
    cyc++;
    repeat (RD_LATENCY + 4) tick();

    run_random(400, 60, 50);

    // Drain: let any pending debug transfer finish, then leave everything idle.
    bus.cpu_req_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (last_dbg_ack) bus.dbg_req_i = 1'b0;
      tick();
    end
    bus.dbg_req_i = 1'b0;
    repeat (RD_LATENCY + 3) tick();
    check32("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check32("dbg_q_drained", 32'(dbg_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
